// File: rtl/axi_rr_arbiter_if.sv
// Bus bundle for axi_rr_arbiter: upstream per-master (s_*) channels, the single
// downstream slave port (m_*) and the grant status vectors.
interface axi_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
);
  // upstream masters
  logic [NUM_MASTERS-1:0]                s_ar_valid_i;
  logic [NUM_MASTERS-1:0]                s_ar_ready_o;
  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_ar_addr_i;
  logic [NUM_MASTERS*AXI_LEN_WIDTH-1:0]  s_ar_len_i;
  logic [NUM_MASTERS-1:0]                s_r_valid_o;
  logic [NUM_MASTERS-1:0]                s_r_ready_i;
  logic [AXI_DATA_WIDTH-1:0]             s_r_data_o;
  logic [1:0]                            s_r_resp_o;
  logic                                  s_r_last_o;
  logic [NUM_MASTERS-1:0]                s_aw_valid_i;
  logic [NUM_MASTERS-1:0]                s_aw_ready_o;
  logic [NUM_MASTERS*AXI_ADDR_WIDTH-1:0] s_aw_addr_i;
  logic [NUM_MASTERS*AXI_LEN_WIDTH-1:0]  s_aw_len_i;
  logic [NUM_MASTERS-1:0]                s_w_valid_i;
  logic [NUM_MASTERS-1:0]                s_w_ready_o;
  logic [NUM_MASTERS*AXI_DATA_WIDTH-1:0] s_w_data_i;
  logic [NUM_MASTERS*AXI_STRB_WIDTH-1:0] s_w_strb_i;
  logic [NUM_MASTERS-1:0]                s_w_last_i;
  logic [NUM_MASTERS-1:0]                s_b_valid_o;
  logic [NUM_MASTERS-1:0]                s_b_ready_i;
  logic [1:0]                            s_b_resp_o;
  // downstream slave
  logic                                  m_ar_valid_o;
  logic                                  m_ar_ready_i;
  logic [AXI_ADDR_WIDTH-1:0]             m_ar_addr_o;
  logic [AXI_LEN_WIDTH-1:0]              m_ar_len_o;
  logic                                  m_r_valid_i;
  logic                                  m_r_ready_o;
  logic [AXI_DATA_WIDTH-1:0]             m_r_data_i;
  logic [1:0]                            m_r_resp_i;
  logic                                  m_r_last_i;
  logic                                  m_aw_valid_o;
  logic                                  m_aw_ready_i;
  logic [AXI_ADDR_WIDTH-1:0]             m_aw_addr_o;
  logic [AXI_LEN_WIDTH-1:0]              m_aw_len_o;
  logic                                  m_w_valid_o;
  logic                                  m_w_ready_i;
  logic [AXI_DATA_WIDTH-1:0]             m_w_data_o;
  logic [AXI_STRB_WIDTH-1:0]             m_w_strb_o;
  logic                                  m_w_last_o;
  logic                                  m_b_valid_i;
  logic                                  m_b_ready_o;
  logic [1:0]                            m_b_resp_i;
  // status
  logic [NUM_MASTERS-1:0]                rd_grant_o;
  logic [NUM_MASTERS-1:0]                wr_grant_o;

  // the arbiter's own view
  modport slave (
    input  s_ar_valid_i, s_ar_addr_i, s_ar_len_i, s_r_ready_i,
    input  s_aw_valid_i, s_aw_addr_i, s_aw_len_i,
    input  s_w_valid_i, s_w_data_i, s_w_strb_i, s_w_last_i, s_b_ready_i,
    input  m_ar_ready_i, m_r_valid_i, m_r_data_i, m_r_resp_i, m_r_last_i,
    input  m_aw_ready_i, m_w_ready_i, m_b_valid_i, m_b_resp_i,
    output s_ar_ready_o, s_r_valid_o, s_r_data_o, s_r_resp_o, s_r_last_o,
    output s_aw_ready_o, s_w_ready_o, s_b_valid_o, s_b_resp_o,
    output m_ar_valid_o, m_ar_addr_o, m_ar_len_o, m_r_ready_o,
    output m_aw_valid_o, m_aw_addr_o, m_aw_len_o,
    output m_w_valid_o, m_w_data_o, m_w_strb_o, m_w_last_o, m_b_ready_o,
    output rd_grant_o, wr_grant_o
  );

  // the surrounding masters and slave
  modport master (
    output s_ar_valid_i, s_ar_addr_i, s_ar_len_i, s_r_ready_i,
    output s_aw_valid_i, s_aw_addr_i, s_aw_len_i,
    output s_w_valid_i, s_w_data_i, s_w_strb_i, s_w_last_i, s_b_ready_i,
    output m_ar_ready_i, m_r_valid_i, m_r_data_i, m_r_resp_i, m_r_last_i,
    output m_aw_ready_i, m_w_ready_i, m_b_valid_i, m_b_resp_i,
    input  s_ar_ready_o, s_r_valid_o, s_r_data_o, s_r_resp_o, s_r_last_o,
    input  s_aw_ready_o, s_w_ready_o, s_b_valid_o, s_b_resp_o,
    input  m_ar_valid_o, m_ar_addr_o, m_ar_len_o, m_r_ready_o,
    input  m_aw_valid_o, m_aw_addr_o, m_aw_len_o,
    input  m_w_valid_o, m_w_data_o, m_w_strb_o, m_w_last_o, m_b_ready_o,
    input  rd_grant_o, wr_grant_o
  );
endinterface

// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI arbiter with independent round-robin read and write
// paths; one transaction per path in flight, no beat buffering.
module axi_rr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_LEN_WIDTH  = 8,
  parameter int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
  input logic             clk,
  input logic             rst,
  axi_rr_arbiter_if.slave bus
);
  localparam int unsigned N  = NUM_MASTERS;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = AXI_ADDR_WIDTH;
  localparam int unsigned LW = AXI_LEN_WIDTH;
  localparam int unsigned DW = AXI_DATA_WIDTH;
  localparam int unsigned SW = AXI_STRB_WIDTH;

  typedef logic [IW-1:0] idx_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_e;

  // First requester at or above ptr, otherwise wrap to the lowest requester.
  function automatic idx_t rr_pick(input logic [N-1:0] req, input idx_t ptr);
    idx_t hi, lo;
    logic found_hi, found_lo;
    hi = '0; lo = '0; found_hi = 1'b0; found_lo = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found_hi && req[i] && idx_t'(i) >= ptr) begin
        hi = idx_t'(i);
        found_hi = 1'b1;
      end
      if (!found_lo && req[i]) begin
        lo = idx_t'(i);
        found_lo = 1'b1;
      end
    end
    return found_hi ? hi : lo;
  endfunction

  function automatic logic [N-1:0] one_hot(input idx_t idx);
    logic [N-1:0] oh;
    for (int unsigned i = 0; i < N; i++) oh[i] = (idx == idx_t'(i));
    return oh;
  endfunction

  function automatic idx_t rr_next(input idx_t idx);
    return (32'(idx) == N - 1) ? '0 : idx_t'(idx + 1'b1);
  endfunction

  rd_state_e    rd_state_q;
  idx_t         rd_owner_q, rd_ptr_q, rd_pick_d;
  logic [N-1:0] rd_grant_q;
  wr_state_e    wr_state_q;
  idx_t         wr_owner_q, wr_ptr_q, wr_pick_d;
  logic [N-1:0] wr_grant_q;

  logic          ar_valid_sel, r_ready_sel, aw_valid_sel, w_valid_sel, w_last_sel, b_ready_sel;
  logic [AW-1:0] ar_addr_sel, aw_addr_sel;
  logic [LW-1:0] ar_len_sel, aw_len_sel;
  logic [DW-1:0] w_data_sel;
  logic [SW-1:0] w_strb_sel;

  assign rd_pick_d = rr_pick(bus.s_ar_valid_i, rd_ptr_q);
  assign wr_pick_d = rr_pick(bus.s_aw_valid_i, wr_ptr_q);

  always_comb begin
    ar_valid_sel = 1'b0;
    ar_addr_sel  = '0;
    ar_len_sel   = '0;
    r_ready_sel  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (rd_owner_q == idx_t'(i)) begin
        ar_valid_sel = bus.s_ar_valid_i[i];
        ar_addr_sel  = bus.s_ar_addr_i[i*AW +: AW];
        ar_len_sel   = bus.s_ar_len_i[i*LW +: LW];
        r_ready_sel  = bus.s_r_ready_i[i];
      end
    end
  end

  always_comb begin
    aw_valid_sel = 1'b0;
    aw_addr_sel  = '0;
    aw_len_sel   = '0;
    w_valid_sel  = 1'b0;
    w_last_sel   = 1'b0;
    w_data_sel   = '0;
    w_strb_sel   = '0;
    b_ready_sel  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (wr_owner_q == idx_t'(i)) begin
        aw_valid_sel = bus.s_aw_valid_i[i];
        aw_addr_sel  = bus.s_aw_addr_i[i*AW +: AW];
        aw_len_sel   = bus.s_aw_len_i[i*LW +: LW];
        w_valid_sel  = bus.s_w_valid_i[i];
        w_last_sel   = bus.s_w_last_i[i];
        w_data_sel   = bus.s_w_data_i[i*DW +: DW];
        w_strb_sel   = bus.s_w_strb_i[i*SW +: SW];
        b_ready_sel  = bus.s_b_ready_i[i];
      end
    end
  end

  // Grant vector doubles as the per-master mask for the upstream valid/ready.
  assign bus.m_ar_valid_o = (rd_state_q == RD_ADDR) & ar_valid_sel;
  assign bus.m_ar_addr_o  = ar_addr_sel;
  assign bus.m_ar_len_o   = ar_len_sel;
  assign bus.s_ar_ready_o = (rd_state_q == RD_ADDR && bus.m_ar_ready_i) ? rd_grant_q : '0;
  assign bus.m_r_ready_o  = (rd_state_q == RD_DATA) & r_ready_sel;
  assign bus.s_r_valid_o  = (rd_state_q == RD_DATA && bus.m_r_valid_i) ? rd_grant_q : '0;
  assign bus.s_r_data_o   = bus.m_r_data_i;
  assign bus.s_r_resp_o   = bus.m_r_resp_i;
  assign bus.s_r_last_o   = bus.m_r_last_i;
  assign bus.rd_grant_o   = rd_grant_q;

  assign bus.m_aw_valid_o = (wr_state_q == WR_ADDR) & aw_valid_sel;
  assign bus.m_aw_addr_o  = aw_addr_sel;
  assign bus.m_aw_len_o   = aw_len_sel;
  assign bus.s_aw_ready_o = (wr_state_q == WR_ADDR && bus.m_aw_ready_i) ? wr_grant_q : '0;
  assign bus.m_w_valid_o  = (wr_state_q == WR_DATA) & w_valid_sel;
  assign bus.m_w_data_o   = w_data_sel;
  assign bus.m_w_strb_o   = w_strb_sel;
  assign bus.m_w_last_o   = w_last_sel;
  assign bus.s_w_ready_o  = (wr_state_q == WR_DATA && bus.m_w_ready_i) ? wr_grant_q : '0;
  assign bus.m_b_ready_o  = (wr_state_q == WR_RESP) & b_ready_sel;
  assign bus.s_b_valid_o  = (wr_state_q == WR_RESP && bus.m_b_valid_i) ? wr_grant_q : '0;
  assign bus.s_b_resp_o   = bus.m_b_resp_i;
  assign bus.wr_grant_o   = wr_grant_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      rd_owner_q <= '0;
      rd_ptr_q   <= '0;
      rd_grant_q <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: if (|bus.s_ar_valid_i) begin
          rd_owner_q <= rd_pick_d;
          rd_grant_q <= one_hot(rd_pick_d);
          rd_state_q <= RD_ADDR;
        end
        RD_ADDR: if (bus.m_ar_valid_o && bus.m_ar_ready_i) rd_state_q <= RD_DATA;
        RD_DATA: if (bus.m_r_valid_i && bus.m_r_ready_o && bus.m_r_last_i) begin
          rd_ptr_q   <= rr_next(rd_owner_q);
          rd_grant_q <= '0;
          rd_state_q <= RD_IDLE;
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wr_owner_q <= '0;
      wr_ptr_q   <= '0;
      wr_grant_q <= '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: if (|bus.s_aw_valid_i) begin
          wr_owner_q <= wr_pick_d;
          wr_grant_q <= one_hot(wr_pick_d);
          wr_state_q <= WR_ADDR;
        end
        WR_ADDR: if (bus.m_aw_valid_o && bus.m_aw_ready_i) wr_state_q <= WR_DATA;
        WR_DATA: if (bus.m_w_valid_o && bus.m_w_ready_i && w_last_sel) wr_state_q <= WR_RESP;
        WR_RESP: if (bus.m_b_valid_i && bus.m_b_ready_o) begin
          wr_ptr_q   <= rr_next(wr_owner_q);
          wr_grant_q <= '0;
          wr_state_q <= WR_IDLE;
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Randomized bench for axi_rr_arbiter: protocol-following masters and slave,
// checked each cycle against a transaction-level round-robin model.
module tb_axi_rr_arbiter;
  localparam int N    = 3;
  localparam int DW   = 64;
  localparam int AW   = 32;
  localparam int LW   = 8;
  localparam int SW   = 8;
  localparam int NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_rr_arbiter_if #(.NUM_MASTERS(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                      .AXI_LEN_WIDTH(LW), .AXI_STRB_WIDTH(SW)) bus ();

  axi_rr_arbiter #(.NUM_MASTERS(N), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW),
                   .AXI_LEN_WIDTH(LW), .AXI_STRB_WIDTH(SW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass = 0;
  int n_checks = 0;
  int cyc = 0;
  bit did_mid_rst = 0;

  // master-side transaction state
  bit          rq_pend[N], rq_busy[N];
  logic [31:0] rq_addr[N];
  int          rq_len[N];
  bit          wq_busy[N], wq_aw_pend[N];
  logic [31:0] wq_addr[N];
  int          wq_len[N], wq_beat[N];
  // slave-side state
  bit          sr_busy, sw_b_pend;
  logic [31:0] sr_addr;
  int          sr_len, sr_beat;
  logic [1:0]  sr_resp, sw_resp;
  // reference arbitration state: owner -1 means idle
  int          mr_own, mr_ptr, mw_own, mw_ptr, mw_ph;
  bit          mr_addr;
  // driven handshake inputs and model-predicted fires
  logic [N-1:0] ar_v, r_rdy, aw_v, w_v, b_rdy;
  bit           m_ar_rdy, m_r_v, m_aw_rdy, m_w_rdy, m_b_v;
  bit           ar_f, r_f, aw_f, w_f, b_f;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
  endtask

  function automatic logic [63:0] rdata(input logic [31:0] addr, input int beat);
    return {addr ^ 32'h5A5A_0F0F, addr + 32'(beat)};
  endfunction

  function automatic logic [63:0] wdata(input int m, input logic [31:0] addr, input int beat);
    return {addr + 32'(beat), 32'hC0DE_0000 | 32'(m << 8) | 32'(beat)};
  endfunction

  function automatic logic [7:0] wstrb(input int m, input int beat);
    return 8'hFF >> ((m + beat) % 8);
  endfunction

  function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int rand_len();
    return ($urandom % 8 == 0) ? 7 : int'($urandom_range(0, 3));
  endfunction

  function automatic logic [N-1:0] oh_of(input int own);
    logic [N-1:0] one;
    one = 1;
    return (own >= 0) ? (one << own) : '0;
  endfunction

  task automatic reset_all();
    for (int m = 0; m < N; m++) begin
      rq_pend[m] = 0; rq_busy[m] = 0; wq_busy[m] = 0; wq_aw_pend[m] = 0; wq_beat[m] = 0;
    end
    sr_busy = 0; sw_b_pend = 0;
    mr_own = -1; mr_ptr = 0; mr_addr = 0;
    mw_own = -1; mw_ptr = 0; mw_ph = 0;
    ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
  endtask

  task automatic step_model();
    int w;
    if (mr_own < 0) begin
      w = rr_winner(ar_v, mr_ptr);
      if (w >= 0) begin mr_own = w; mr_addr = 1; end
    end else if (mr_addr) begin
      if (ar_f) begin
        mr_addr = 0; rq_pend[mr_own] = 0; rq_busy[mr_own] = 1;
        sr_busy = 1; sr_addr = rq_addr[mr_own]; sr_len = rq_len[mr_own]; sr_beat = 0;
      end
    end else if (r_f) begin
      if (sr_beat == sr_len) begin
        rq_busy[mr_own] = 0; sr_busy = 0;
        mr_ptr = (mr_own + 1) % N; mr_own = -1;
      end else sr_beat++;
    end

    if (mw_own < 0) begin
      w = rr_winner(aw_v, mw_ptr);
      if (w >= 0) begin mw_own = w; mw_ph = 0; end
    end else if (mw_ph == 0) begin
      if (aw_f) begin mw_ph = 1; wq_aw_pend[mw_own] = 0; end
    end else if (mw_ph == 1) begin
      if (w_f) begin
        if (wq_beat[mw_own] == wq_len[mw_own]) begin
          mw_ph = 2; sw_b_pend = 1; sw_resp = 2'($urandom);
        end
        wq_beat[mw_own]++;
      end
    end else if (b_f) begin
      wq_busy[mw_own] = 0; sw_b_pend = 0;
      mw_ptr = (mw_own + 1) % N; mw_own = -1;
    end
  endtask

  task automatic drive();
    int p;
    p = ((cyc / 400) % 2 == 1) ? 100 : 25;
    for (int m = 0; m < N; m++) begin
      if (!rq_pend[m] && !rq_busy[m] && ($urandom % 100) < p) begin
        rq_pend[m] = 1; rq_addr[m] = $urandom & ~32'h7; rq_len[m] = rand_len();
      end
      if (!wq_busy[m] && ($urandom % 100) < p) begin
        wq_busy[m] = 1; wq_aw_pend[m] = 1; wq_beat[m] = 0;
        wq_addr[m] = $urandom & ~32'h7; wq_len[m] = rand_len();
      end
      ar_v[m]  = rq_pend[m];
      r_rdy[m] = ($urandom % 10) < 7;
      aw_v[m]  = wq_aw_pend[m];
      w_v[m]   = wq_busy[m] && (wq_beat[m] <= wq_len[m]) && (($urandom % 10) < 7);
      b_rdy[m] = ($urandom % 10) < 7;
      bus.s_ar_addr_i[m*AW +: AW] = rq_addr[m];
      bus.s_ar_len_i[m*LW +: LW]  = LW'(rq_len[m]);
      bus.s_aw_addr_i[m*AW +: AW] = wq_addr[m];
      bus.s_aw_len_i[m*LW +: LW]  = LW'(wq_len[m]);
      bus.s_w_data_i[m*DW +: DW]  = wdata(m, wq_addr[m], wq_beat[m]);
      bus.s_w_strb_i[m*SW +: SW]  = wstrb(m, wq_beat[m]);
      bus.s_w_last_i[m]           = wq_busy[m] && (wq_beat[m] == wq_len[m]);
    end
    bus.s_ar_valid_i = ar_v;
    bus.s_r_ready_i  = r_rdy;
    bus.s_aw_valid_i = aw_v;
    bus.s_w_valid_i  = w_v;
    bus.s_b_ready_i  = b_rdy;

    m_ar_rdy = ($urandom % 10) < 6;
    m_r_v    = sr_busy && (($urandom % 10) < 6);
    sr_resp  = 2'($urandom);
    m_aw_rdy = ($urandom % 10) < 6;
    m_w_rdy  = ($urandom % 10) < 6;
    m_b_v    = sw_b_pend && (($urandom % 10) < 6);
    bus.m_ar_ready_i = m_ar_rdy;
    bus.m_r_valid_i  = m_r_v;
    bus.m_r_data_i   = sr_busy ? rdata(sr_addr, sr_beat) : 64'({$urandom, $urandom});
    bus.m_r_resp_i   = sr_resp;
    bus.m_r_last_i   = sr_busy && (sr_beat == sr_len);
    bus.m_aw_ready_i = m_aw_rdy;
    bus.m_w_ready_i  = m_w_rdy;
    bus.m_b_valid_i  = m_b_v;
    bus.m_b_resp_i   = sw_resp;
  endtask

  task automatic check_cycle();
    logic [N-1:0] oh;
    bit ex, dp;
    oh = oh_of(mr_own);
    check("rd_grant", 64'(bus.rd_grant_o), 64'(oh));
    ex = (mr_own >= 0) && mr_addr && ar_v[mr_own];
    check("m_ar_valid", 64'(bus.m_ar_valid_o), 64'(ex));
    if (ex) begin
      check("m_ar_addr", 64'(bus.m_ar_addr_o), 64'(rq_addr[mr_own]));
      check("m_ar_len", 64'(bus.m_ar_len_o), 64'(rq_len[mr_own]));
    end
    check("s_ar_ready", 64'(bus.s_ar_ready_o), 64'((mr_own >= 0 && mr_addr && m_ar_rdy) ? oh : '0));
    ar_f = ex && m_ar_rdy;
    dp = (mr_own >= 0) && !mr_addr;
    ex = dp && r_rdy[mr_own];
    check("m_r_ready", 64'(bus.m_r_ready_o), 64'(ex));
    r_f = ex && m_r_v;
    check("s_r_valid", 64'(bus.s_r_valid_o), 64'((dp && m_r_v) ? oh : '0));
    if (dp && m_r_v) begin
      check("s_r_data", bus.s_r_data_o, rdata(sr_addr, sr_beat));
      check("s_r_last", 64'(bus.s_r_last_o), 64'(sr_beat == sr_len));
      check("s_r_resp", 64'(bus.s_r_resp_o), 64'(sr_resp));
    end

    oh = oh_of(mw_own);
    check("wr_grant", 64'(bus.wr_grant_o), 64'(oh));
    ex = (mw_own >= 0) && (mw_ph == 0) && aw_v[mw_own];
    check("m_aw_valid", 64'(bus.m_aw_valid_o), 64'(ex));
    if (ex) begin
      check("m_aw_addr", 64'(bus.m_aw_addr_o), 64'(wq_addr[mw_own]));
      check("m_aw_len", 64'(bus.m_aw_len_o), 64'(wq_len[mw_own]));
    end
    check("s_aw_ready", 64'(bus.s_aw_ready_o), 64'((mw_own >= 0 && mw_ph == 0 && m_aw_rdy) ? oh : '0));
    aw_f = ex && m_aw_rdy;
    ex = (mw_own >= 0) && (mw_ph == 1) && w_v[mw_own];
    check("m_w_valid", 64'(bus.m_w_valid_o), 64'(ex));
    if (ex) begin
      check("m_w_data", bus.m_w_data_o, wdata(mw_own, wq_addr[mw_own], wq_beat[mw_own]));
      check("m_w_strb", 64'(bus.m_w_strb_o), 64'(wstrb(mw_own, wq_beat[mw_own])));
      check("m_w_last", 64'(bus.m_w_last_o), 64'(wq_beat[mw_own] == wq_len[mw_own]));
    end
    check("s_w_ready", 64'(bus.s_w_ready_o), 64'((mw_own >= 0 && mw_ph == 1 && m_w_rdy) ? oh : '0));
    w_f = ex && m_w_rdy;
    ex = (mw_own >= 0) && (mw_ph == 2) && b_rdy[mw_own];
    check("m_b_ready", 64'(bus.m_b_ready_o), 64'(ex));
    b_f = ex && m_b_v;
    check("s_b_valid", 64'(bus.s_b_valid_o), 64'((mw_own >= 0 && mw_ph == 2 && m_b_v) ? oh : '0));
    if (mw_own >= 0 && mw_ph == 2 && m_b_v)
      check("s_b_resp", 64'(bus.s_b_resp_o), 64'(sw_resp));
  endtask

  initial begin
    reset_all();
    ar_v = '0; r_rdy = '0; aw_v = '0; w_v = '0; b_rdy = '0;
    bus.s_ar_valid_i = '0; bus.s_ar_addr_i = '0; bus.s_ar_len_i = '0; bus.s_r_ready_i = '0;
    bus.s_aw_valid_i = '0; bus.s_aw_addr_i = '0; bus.s_aw_len_i = '0;
    bus.s_w_valid_i = '0; bus.s_w_data_i = '0; bus.s_w_strb_i = '0; bus.s_w_last_i = '0;
    bus.s_b_ready_i = '0;
    bus.m_ar_ready_i = 1'b0; bus.m_r_valid_i = 1'b0; bus.m_r_data_i = '0; bus.m_r_resp_i = '0;
    bus.m_r_last_i = 1'b0; bus.m_aw_ready_i = 1'b0; bus.m_w_ready_i = 1'b0;
    bus.m_b_valid_i = 1'b0; bus.m_b_resp_i = '0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      if (rst) reset_all();
      else step_model();
      // a reset landing mid read-burst must abandon it and restart arbitration from master 0
      if (cyc < 2 || cyc == 2000) rst = 1'b1;
      else if (!did_mid_rst && cyc > 1200 && mr_own >= 0 && !mr_addr) begin
        rst = 1'b1;
        did_mid_rst = 1;
      end else rst = 1'b0;
      drive();
      @(negedge clk);
      check_cycle();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
N-master to 1-slave AXI arbiter; successor of the fixed 2-port IFU/LSU arbiter. Read and write paths are arbitrated independently with round-robin fairness, so no master is starved. Supports multi-beat bursts (len/last) and a configurable master count. Sits between the IFU/LSU/DMA-style masters and the single memory/crossbar slave port.

Parameters:
NUM_MASTERS, 2, number of master ports (2..8)
AXI_DATA_WIDTH, 64, data bus width
AXI_ADDR_WIDTH, 32, address width
AXI_LEN_WIDTH, 8, burst length field width (beats = len+1)
AXI_STRB_WIDTH, AXI_DATA_WIDTH/8, write strobe width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_ar_valid_i / s_ar_ready_o  in/out  NUM_MASTERS  per-master AR handshake
s_ar_addr_i  in  NUM_MASTERS*AXI_ADDR_WIDTH  packed AR addresses, master i at [i*W +: W]
s_ar_len_i  in  NUM_MASTERS*AXI_LEN_WIDTH  packed AR burst lengths
s_r_valid_o / s_r_ready_i  out/in  NUM_MASTERS  per-master R handshake
s_r_data_o  out  AXI_DATA_WIDTH  shared R data, qualified by s_r_valid_o
s_r_resp_o  out  2  shared R response
s_r_last_o  out  1  shared R last
s_aw_valid_i / s_aw_ready_o  in/out  NUM_MASTERS  per-master AW handshake
s_aw_addr_i  in  NUM_MASTERS*AXI_ADDR_WIDTH  packed AW addresses
s_aw_len_i  in  NUM_MASTERS*AXI_LEN_WIDTH  packed AW lengths
s_w_valid_i / s_w_ready_o  in/out  NUM_MASTERS  per-master W handshake
s_w_data_i  in  NUM_MASTERS*AXI_DATA_WIDTH  packed W data
s_w_strb_i  in  NUM_MASTERS*AXI_STRB_WIDTH  packed W strobes
s_w_last_i  in  NUM_MASTERS  W last per master
s_b_valid_o / s_b_ready_i  out/in  NUM_MASTERS  per-master B handshake
s_b_resp_o  out  2  shared B response
m_ar_valid_o, m_ar_ready_i, m_ar_addr_o, m_ar_len_o  slave-side AR channel
m_r_valid_i, m_r_ready_o, m_r_data_i, m_r_resp_i, m_r_last_i  slave-side R channel
m_aw_valid_o, m_aw_ready_i, m_aw_addr_o, m_aw_len_o  slave-side AW channel
m_w_valid_o, m_w_ready_i, m_w_data_o, m_w_strb_o, m_w_last_o  slave-side W channel
m_b_valid_i, m_b_ready_o, m_b_resp_i  slave-side B channel
rd_grant_o  out  NUM_MASTERS  one-hot current read owner (0 when idle)
wr_grant_o  out  NUM_MASTERS  one-hot current write owner (0 when idle)

Behaviour:
- Reset: both FSMs go to IDLE, grants 0, priority pointers 0 (master 0 highest), every valid/ready output 0. A reset mid-burst abandons the transaction. The slave is reset alongside.
- Read FSM, states IDLE -> ADDR -> DATA -> IDLE:
  - IDLE: if any s_ar_valid_i is set, register the grant to the first requester at or after rd_ptr (cyclic scan). Go to ADDR the next cycle. One-cycle arbitration latency.
  - ADDR: mux the owner's AR onto m_ar_*; s_ar_ready_o[owner]=m_ar_ready_i. On handshake, go to DATA.
  - DATA: m_r_ready_o=s_r_ready_i[owner]; s_r_valid_o[owner]=m_r_valid_i. On an R handshake with m_r_last_i=1, rd_ptr=(owner+1) mod NUM_MASTERS, grant clears, go to IDLE.
- Write FSM, states IDLE -> ADDR -> DATA -> RESP -> IDLE, with the same arbitration:
  - ADDR: forward AW.
  - DATA: forward W beats. Leave on a W handshake with s_w_last_i[owner]=1.
  - RESP: forward B. On a B handshake, wr_ptr=owner+1 mod N and go to IDLE.
- Non-owners always see ready=0 and valid=0. Shared data/resp outputs are don't-care when valid=0.
- m_*_valid_o is 0 outside the matching state. The arbiter adds no beat buffering, so data phases have zero added latency.
- Read and write paths are fully independent; the same master may own both at once.
- The grant is stable for the whole transaction. A requester dropping valid in ADDR is a protocol violation (not handled).
- Beat count is not checked against len; last alone terminates the transaction.

Test Plan:
- Single read: master 1 AR addr 0x8000_0000 len 0, slave returns 0xDEAD_BEEF -> rd_grant_o=2'b10 one cycle after valid, m_ar_addr_o=0x8000_0000, only s_r_valid_o[1] pulses, grant clears after the last beat.
- Round-robin: NUM_MASTERS=3, all three issue reads continuously -> grant order 0,1,2,0; no master waits more than 2 transactions.
- Burst: master 0 read len 3 while master 1 requests -> master 0 receives 4 beats, master 1 is granted only after m_r_last_i handshake.
- Backpressure: s_r_ready_i[owner] low for 3 cycles mid-burst -> m_r_ready_o low for the same cycles, no beat lost or duplicated.
- Concurrent: master 0 write (len 1, strb 0xFF) and master 1 read simultaneously -> both proceed in parallel, B reaches only master 0, R reaches only master 1.
- Reset mid-burst: assert rst during read DATA -> next cycle all grants 0, all valids/readies 0, rd_ptr=0.
